// File: rtl/rtc_bus_responder_if.sv
// Multiplexed RTC bus pins: strobes, phase select and 8-bit data.
// The generator drives the strobes; the responder drives read data and pad enable.
interface rtc_bus_responder_if #(
   parameter int DATA_W = 8
);
   logic              CS;
   logic              WR;
   logic              RD;
   logic              AD;
   logic [DATA_W-1:0] dato_in;
   logic [DATA_W-1:0] dato_out;
   logic              dato_oe;

   modport master (
      output CS, WR, RD, AD, dato_in,
      input  dato_out, dato_oe
   );

   modport slave (
      input  CS, WR, RD, AD, dato_in,
      output dato_out, dato_oe
   );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC bus responder: synchronized CS/WR/RD/AD decode into a small register file.
// Define RTC_AUTOINC_EN to advance addr_reg after each committed write or completed read.
module rtc_bus_responder #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   rtc_bus_responder_if.slave  bus,
   input  logic                host_we,
   input  logic [IDX_W-1:0]    host_idx,
   input  logic [DATA_W-1:0]   host_data,
   output logic                wr_stb,
   output logic [IDX_W-1:0]    wr_idx,
   output logic [DATA_W-1:0]   wr_data,
   output logic                bus_err
);
   localparam int NREG = 2 ** IDX_W;

`ifdef RTC_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      ADDR_WR,
      DATA_WR,
      DATA_RD
   } state_t;

   state_t state, nxt;

   logic [1:0]        cs_sy, wr_sy, rd_sy, ad_sy;
   logic [DATA_W-1:0] din_s1, din_s;
   logic              cs_s, wr_s, rd_s, ad_s;
   logic              wr_q, rd_q, wr_rise, rd_rise;
   logic [DATA_W-1:0] samp;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] regs [NREG];
   logic              lock, in_rng;
   logic              do_addr, do_wr, do_err, do_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_sy  <= 2'b11;
         wr_sy  <= 2'b11;
         rd_sy  <= 2'b11;
         ad_sy  <= 2'b11;
         din_s1 <= '0;
         din_s  <= '0;
         wr_q   <= 1'b1;
         rd_q   <= 1'b1;
         samp   <= '0;
      end else begin
         cs_sy  <= {cs_sy[0], bus.CS};
         wr_sy  <= {wr_sy[0], bus.WR};
         rd_sy  <= {rd_sy[0], bus.RD};
         ad_sy  <= {ad_sy[0], bus.AD};
         din_s1 <= bus.dato_in;
         din_s  <= din_s1;
         wr_q   <= wr_s;
         rd_q   <= rd_s;
         samp   <= din_s;
      end
   end

   assign cs_s    = cs_sy[1];
   assign wr_s    = wr_sy[1];
   assign rd_s    = rd_sy[1];
   assign ad_s    = ad_sy[1];
   assign wr_rise = wr_s & ~wr_q;
   assign rd_rise = rd_s & ~rd_q;
   assign in_rng  = (addr_reg >> IDX_W) == '0;

   // samp lags din_s by one cycle, so a commit ignores data at the edge
   always_comb begin
      nxt     = state;
      do_addr = 1'b0;
      do_wr   = 1'b0;
      do_err  = 1'b0;
      do_inc  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!cs_s && !lock) begin
               if (!wr_s && !rd_s)      do_err = 1'b1;
               else if (!rd_s && !ad_s) do_err = 1'b1;
               else if (!wr_s)          nxt = ad_s ? DATA_WR : ADDR_WR;
               else if (!rd_s)          nxt = DATA_RD;
            end
         end
         ADDR_WR: begin
            if (wr_rise) begin
               do_addr = 1'b1;
               nxt     = IDLE;
            end else if (cs_s) begin
               nxt = IDLE;
            end else if (!rd_s || ad_s) begin
               do_err = 1'b1;
               nxt    = IDLE;
            end
         end
         DATA_WR: begin
            if (wr_rise) begin
               nxt = IDLE;
               if (in_rng) begin
                  do_wr  = 1'b1;
                  do_inc = 1'b1;
               end else begin
                  do_err = 1'b1;
               end
            end else if (cs_s) begin
               nxt = IDLE;
            end else if (!rd_s || !ad_s) begin
               do_err = 1'b1;
               nxt    = IDLE;
            end
         end
         DATA_RD: begin
            if (rd_rise) begin
               do_inc = 1'b1;
               nxt    = IDLE;
            end else if (cs_s) begin
               nxt = IDLE;
            end else if (!wr_s || !ad_s) begin
               do_err = 1'b1;
               nxt    = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // lock keeps a lingering bad strobe from re-triggering after an error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         lock     <= 1'b0;
         addr_reg <= '0;
         wr_stb   <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= '0;
         bus_err  <= 1'b0;
      end else begin
         state   <= nxt;
         wr_stb  <= do_wr;
         bus_err <= do_err;
         if (do_err)
            lock <= 1'b1;
         else if (cs_s || (wr_s && rd_s))
            lock <= 1'b0;
         if (do_wr) begin
            wr_idx  <= addr_reg[IDX_W-1:0];
            wr_data <= samp;
         end
         if (do_addr)
            addr_reg <= ADDR_W'(samp);
         else if (AUTOINC && do_inc)
            addr_reg <= addr_reg + ADDR_W'(1);
      end
   end

   // bus commit is applied last so it wins a same-index host write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         if (host_we)
            regs[host_idx] <= host_data;
         if (do_wr)
            regs[addr_reg[IDX_W-1:0]] <= samp;
      end
   end

   assign bus.dato_oe  = (state == DATA_RD);
   assign bus.dato_out = (state == DATA_RD && in_rng) ?
                         regs[addr_reg[IDX_W-1:0]] : '0;

endmodule
